inst_pc_control: RTL
====================

# inst_pc_control

Program-counter sequencer for the instruction memory path. It sits directly upstream of the instruction loop control stage. It produces the program counter and the run/stall qualifiers that stage consumes, and it consumes that stage's jump request, jump address and loop-done status. It also owns the start/run/done handshake with the CSR/host side.

## Interface
- `InstMemAddrWidth`, default 32: PC and address width.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous reset, active-low.
- `clr_i`  in  1: synchronous clear to IDLE.
- `start_i`  in  1: start request, sampled in IDLE only.
- `stall_i`  in  1: hold PC and state.
- `prog_end_addr_i`  in  InstMemAddrWidth: last program address, used for loop-free programs.
- `inst_jump_i`  in  1: jump request from loop control.
- `inst_jump_addr_i`  in  InstMemAddrWidth: jump target.
- `inst_loop_done_i`  in  1: outermost loop finished.
- `inst_pc_o`  out  InstMemAddrWidth: current PC, driven to memory and loop control.
- `inst_en_o`  out  1: high in RUN, drives loop control `en_i`.
- `inst_valid_o`  out  1: RUN && !stall_i && !dbg_en; the instruction at `inst_pc_o` executes this cycle.
- `busy_o`  out  1: state != IDLE.
- `done_o`  out  1: single-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `inst_pc_o` = 0.
  - `start_i` -> RUN. PC stays 0, so the first executed address is 0.
- **RUN**, on cycles where stall_i=0 and dbg_en=0, in this priority:
  - `inst_loop_done_i` -> DONE, PC held.
  - `inst_jump_i` -> PC <= `inst_jump_addr_i`.
  - PC == `prog_end_addr_i` -> DONE, PC held.
  - Otherwise PC <= PC+1, modulo 2^InstMemAddrWidth (wrap-around, no error).
- **DONE**
  - `done_o`=1 for exactly one cycle.
  - Next state IDLE; PC <= 0.
- **Stall**: while stall_i=1, the state and PC are frozen in every state except DONE. DONE always completes.
- **Clear**: `clr_i` forces IDLE and PC=0 from any state. It overrides start, jump and done arriving in the same cycle.
- **start_i** is ignored in RUN and DONE.
- **Reset values**: state IDLE, `inst_pc_o`=0, `inst_en_o`=0, `inst_valid_o`=0, `busy_o`=0, `done_o`=0.

## Timing
- PC is registered. Jump, done and end are evaluated combinationally from the current PC and take effect at the next edge. Jump latency is 1 cycle.
- Start latency: `start_i` at edge N gives `inst_en_o`=1 and `inst_valid_o`=1 from N+1, with PC=0.
- Done latency: the completing condition in cycle N gives DONE (`done_o`=1, `inst_en_o`=0) in N+1 and IDLE in N+2. Dropping `inst_en_o` clears the loop counters downstream.
- Jump and end address in the same cycle: the jump wins.
- Back-to-back runs: `start_i` may be asserted in the cycle after DONE (IDLE) and is accepted.

## Configuration
- `INST_PC_DBG_EN` **defined**: adds the following ports.
  - `dbg_en_i` in 1: freezes PC/state like a stall and is forwarded to loop control `dbg_en_i` via `dbg_en_o`.
  - `dbg_addr_i` in InstMemAddrWidth: while dbg_en_i=1, `inst_pc_o` = `dbg_addr_i` combinationally. The registered PC is untouched and resumes on release.
- **Not defined**: these ports are absent, internal dbg_en is 0, and `dbg_en_o` is not present.

## Structure
- Shared package `hv_inst_pkg`: FSM state enum `inst_pc_state_t` {IDLE, RUN, DONE}, and the default width constant `InstMemAddrWidthDef`=32.
- No sub-module. The block is a single FSM plus PC register, and is instantiated beside loop control in the instruction memory top.

## Test plan
- start_i=1 at cycle 0, prog_end_addr_i=5, no jumps -> valid PCs 0,1,2,3,4,5 in cycles 1–6; done_o=1 at cycle 7; busy_o=0 at cycle 8.
- Jump when PC=3 with jump_addr=1, repeated 2 times, end=4 -> PC sequence 0,1,2,3,1,2,3,1,2,3,4; then done.
- inst_loop_done_i=1 at PC=7 with end=20 -> DONE next cycle, PC held at 7 during DONE, then 0.
- stall_i held 3 cycles at PC=2 -> PC stays 2 and valid=0 for 3 cycles, then 3 follows; stall asserted in DONE has no effect.
- clr_i concurrent with inst_jump_i at PC=9 -> IDLE next cycle, PC=0, no done_o; asynchronous reset mid-run -> all outputs 0 immediately.
- With INST_PC_DBG_EN: dbg_en_i=1 and dbg_addr_i=0x40 at PC=4 -> inst_pc_o=0x40 and valid=0; on release, PC=4 resumes and advances to 5.

Source files
------------

// File: rtl/hv_inst_pkg.sv
// Shared types and constants for the instruction memory path.
package hv_inst_pkg;

  localparam int InstMemAddrWidthDef = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inst_pc_state_t;

endpackage

// File: rtl/inst_pc_control.sv
// Program-counter sequencer: IDLE/RUN/DONE FSM plus registered PC feeding loop control.
// Optional debug override ports are enabled by defining INST_PC_DBG_EN.
module inst_pc_control
  import hv_inst_pkg::*;
#(
  parameter int InstMemAddrWidth = InstMemAddrWidthDef
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        start_i,
  input  logic                        stall_i,
  input  logic [InstMemAddrWidth-1:0] prog_end_addr_i,
  input  logic                        inst_jump_i,
  input  logic [InstMemAddrWidth-1:0] inst_jump_addr_i,
  input  logic                        inst_loop_done_i,
`ifdef INST_PC_DBG_EN
  input  logic                        dbg_en_i,
  input  logic [InstMemAddrWidth-1:0] dbg_addr_i,
  output logic                        dbg_en_o,
`endif
  output logic [InstMemAddrWidth-1:0] inst_pc_o,
  output logic                        inst_en_o,
  output logic                        inst_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam logic [InstMemAddrWidth-1:0] PcOne = InstMemAddrWidth'(1);

  inst_pc_state_t              state_q, state_d;
  logic [InstMemAddrWidth-1:0] pc_q, pc_d;
  logic                        dbg_en;
  logic                        hold;

`ifdef INST_PC_DBG_EN
  assign dbg_en   = dbg_en_i;
  assign dbg_en_o = dbg_en_i;
`else
  assign dbg_en = 1'b0;
`endif

  // Debug freezes the sequencer exactly like a stall; DONE ignores both.
  assign hold = stall_i | dbg_en;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (!hold && start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (inst_loop_done_i) begin
            state_d = DONE;
          end else if (inst_jump_i) begin
            pc_d = inst_jump_addr_i;
          end else if (pc_q == prog_end_addr_i) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + PcOne;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pc_d    = '0;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    if (clr_i) begin
      state_d = IDLE;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef INST_PC_DBG_EN
  // The debug address only overrides the visible PC; pc_q resumes untouched.
  assign inst_pc_o = dbg_en_i ? dbg_addr_i : pc_q;
`else
  assign inst_pc_o = pc_q;
`endif

  assign inst_en_o    = (state_q == RUN);
  assign inst_valid_o = (state_q == RUN) && !stall_i && !dbg_en;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

endmodule
